// File: rtl/result_serializer_pkg.sv
// result_serializer_pkg
// Shared types and default sizes for the result serializer.
//   ser_state_t    : serializer FSM states (SER_PAR only reachable when the
//                    RESULT_SERIALIZER_PARITY_EN macro is defined)
//   DEFAULT_WIDTH  : result bits per frame (one per compressor column)
//   DEFAULT_FCNT_W : completed-frame counter width
//   SER_IDX_W      : bit-index counter width for the default frame size
package result_serializer_pkg;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_SHIFT = 2'd1,
    SER_PAR   = 2'd2
  } ser_state_t;

  localparam int DEFAULT_WIDTH  = 48;
  localparam int DEFAULT_FCNT_W = 16;
  localparam int SER_IDX_W      = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/ser_shift_reg.sv
// ser_shift_reg
// WIDTH-bit parallel-load, shift-right register. Bit 0 is the next serial bit.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset, clears the register
//   load     : capture din (has priority over shift_en)
//   shift_en : shift right by one, zero fill at the top
//   din      : parallel load data
//   lsb      : current bit 0
module ser_shift_reg #(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             lsb
);

  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= din;
    end else if (shift_en) begin
      data_reg <= {1'b0, data_reg[WIDTH-1:1]};
    end
  end

  assign lsb = data_reg[0];

endmodule

// File: rtl/result_serializer.sv
// result_serializer
// Captures a WIDTH-bit compressor column result in one transfer and streams it
// LSB-first over a single-bit valid/ready port. Optional even-parity trailer
// bit when RESULT_SERIALIZER_PARITY_EN is defined.
// Ports:
//   clk       : sole clock
//   rst_n     : synchronous active-low reset
//   col       : parallel result, bit i = column i
//   cap_valid : col valid for capture
//   cap_ready : idle, capture accepted this cycle if cap_valid
//   ser_out   : current serial bit
//   ser_valid : ser_out valid
//   ser_ready : downstream accepts ser_out
//   ser_last  : final bit of frame
//   busy      : frame in progress
//   frame_cnt : completed frames, wrapping
// All outputs decode registered state only; nothing depends combinationally
// on ser_ready or cap_valid.
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int FCNT_W = DEFAULT_FCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  col,
  input  logic              cap_valid,
  output logic              cap_ready,
  output logic              ser_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  ser_state_t        state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg;
  logic [FCNT_W-1:0] frame_cnt_reg;
  logic              load;
  logic              shift_en;
  logic              frame_done;
  logic              lsb;
  logic              last_bit;

`ifdef RESULT_SERIALIZER_PARITY_EN
  logic              par_reg;
`endif

  ser_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift_en (shift_en),
    .din      (col),
    .lsb      (lsb)
  );

  assign last_bit = (idx_reg == LAST_IDX);

  // In SHIFT and PAR ser_valid is always high, so ser_ready alone means the
  // current bit is accepted.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      SER_IDLE: begin
        if (cap_valid) begin
          load       = 1'b1;
          state_next = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (ser_ready) begin
          shift_en = 1'b1;
          if (last_bit) begin
`ifdef RESULT_SERIALIZER_PARITY_EN
            state_next = SER_PAR;
`else
            state_next = SER_IDLE;
            frame_done = 1'b1;
`endif
          end
        end
      end
`ifdef RESULT_SERIALIZER_PARITY_EN
      SER_PAR: begin
        if (ser_ready) begin
          state_next = SER_IDLE;
          frame_done = 1'b1;
        end
      end
`endif
      default: state_next = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= SER_IDLE;
      idx_reg       <= '0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        idx_reg <= '0;
      end else if (shift_en) begin
        // Wrap on the last bit so the index never exceeds WIDTH-1.
        idx_reg <= last_bit ? '0 : idx_reg + IDX_W'(1);
      end
      if (frame_done) begin
        frame_cnt_reg <= frame_cnt_reg + FCNT_W'(1);
      end
    end
  end

`ifdef RESULT_SERIALIZER_PARITY_EN
  // Even parity: XOR of every data bit accepted in this frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_reg <= 1'b0;
    end else if (load) begin
      par_reg <= 1'b0;
    end else if (shift_en) begin
      par_reg <= par_reg ^ lsb;
    end
  end

  assign ser_out  = (state_reg == SER_SHIFT) ? lsb :
                    (state_reg == SER_PAR)   ? par_reg : 1'b0;
  assign ser_last = (state_reg == SER_PAR);
`else
  assign ser_out  = (state_reg == SER_SHIFT) && lsb;
  assign ser_last = (state_reg == SER_SHIFT) && last_bit;
`endif

  assign cap_ready = (state_reg == SER_IDLE);
  assign ser_valid = (state_reg != SER_IDLE);
  assign busy      = (state_reg != SER_IDLE);
  assign frame_cnt = frame_cnt_reg;

endmodule
